// File: rtl/feature_pad_stream.sv
// feature_pad_stream
//   Streams a feature map in raster order (rows, columns, channel groups) and
//   inserts zero-point beats around it. Top/bottom/left/right pad amounts are
//   independent, and the input size and channel-group count are set at run time.
//   Both sides use ready/valid. The output side is one register stage with
//   backpressure. There is no internal row FIFO.
//
//   Optional macro FEATURE_PAD_ABORT_EN adds i_abort. This is a synchronous
//   abort from RUN or DRAIN. It returns to IDLE, drops o_m_valid and gives no done.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_start               one-cycle pulse in IDLE, latches all i_cfg_*
//   i_cfg_in_w/_in_h      input columns / rows
//   i_cfg_cgrp            channel groups per pixel (0 behaves as 1)
//   i_cfg_pad_*           pad amounts (top, bot, left, right)
//   i_cfg_zero_point      pad element value
//   i_s_data/_valid, o_s_ready   input beat stream
//   o_m_data/_valid, i_m_ready   output beat stream (registered)
//   o_out_w, o_out_h      latched padded width / height
//   o_busy                high in RUN and DRAIN
//   o_done                one-cycle pulse after the final beat is accepted
//   i_abort               (FEATURE_PAD_ABORT_EN only) abort the job in flight
module feature_pad_stream #(
    parameter int DATA_W = 8,
    parameter int LANES  = 64,
    parameter int SIZE_W = 12,
    parameter int CGRP_W = 10,
    parameter int PAD_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [SIZE_W-1:0]       i_cfg_in_w,
    input  logic [SIZE_W-1:0]       i_cfg_in_h,
    input  logic [CGRP_W-1:0]       i_cfg_cgrp,
    input  logic [PAD_W-1:0]        i_cfg_pad_top,
    input  logic [PAD_W-1:0]        i_cfg_pad_bot,
    input  logic [PAD_W-1:0]        i_cfg_pad_left,
    input  logic [PAD_W-1:0]        i_cfg_pad_right,
    input  logic [DATA_W-1:0]       i_cfg_zero_point,
`ifdef FEATURE_PAD_ABORT_EN
    input  logic                    i_abort,
`endif
    input  logic [DATA_W*LANES-1:0] i_s_data,
    input  logic                    i_s_valid,
    output logic                    o_s_ready,
    output logic [DATA_W*LANES-1:0] o_m_data,
    output logic                    o_m_valid,
    input  logic                    i_m_ready,
    output logic [SIZE_W-1:0]       o_out_w,
    output logic [SIZE_W-1:0]       o_out_h,
    output logic                    o_busy,
    output logic                    o_done
);

    // state      | meaning
    // S_IDLE     | waiting for i_start
    // S_RUN      | emitting pad/data beats
    // S_DRAIN    | final beat emitted, waiting for it to be accepted
    // S_DONE     | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    logic [SIZE_W-1:0]       r_in_w, r_in_h, r_out_w, r_out_h;
    logic [CGRP_W-1:0]       r_cgrp_max;
    logic [PAD_W-1:0]        r_top, r_left;
    logic [DATA_W-1:0]       r_zp;
    logic [CGRP_W-1:0]       r_g;
    logic [SIZE_W-1:0]       r_c, r_r;
    logic [DATA_W*LANES-1:0] r_m_data;
    logic                    r_m_valid;

    logic [SIZE_W-1:0] w_out_w, w_out_h;
    logic              w_run, w_abort, w_adv, w_pad, w_fire, w_last;
    logic              w_g_max, w_c_max, w_r_max;

    assign w_out_w = i_cfg_in_w + SIZE_W'(i_cfg_pad_left) + SIZE_W'(i_cfg_pad_right);
    assign w_out_h = i_cfg_in_h + SIZE_W'(i_cfg_pad_top) + SIZE_W'(i_cfg_pad_bot);

`ifdef FEATURE_PAD_ABORT_EN
    assign w_abort = i_abort && (r_state == S_RUN || r_state == S_DRAIN);
`else
    assign w_abort = 1'b0;
`endif

    // A zero-size input makes every position fall into a pad band.
    assign w_pad = (r_r < SIZE_W'(r_top)) || (r_r >= SIZE_W'(r_top) + r_in_h) ||
                   (r_c < SIZE_W'(r_left)) || (r_c >= SIZE_W'(r_left) + r_in_w);

    assign w_adv   = !r_m_valid || i_m_ready;
    assign w_fire  = w_run && !w_abort && w_adv && (w_pad || i_s_valid);
    assign w_g_max = (r_g == r_cgrp_max);
    assign w_c_max = (r_c == r_out_w - SIZE_W'(1));
    assign w_r_max = (r_r == r_out_h - SIZE_W'(1));
    assign w_last  = w_g_max && w_c_max && w_r_max;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start)
                    w_state_nxt = (w_out_w == '0 || w_out_h == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_abort)                 w_state_nxt = S_IDLE;
                else if (w_fire && w_last)   w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_abort)                        w_state_nxt = S_IDLE;
                else if (!r_m_valid || i_m_ready)   w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_run  = (r_state == S_RUN);
        o_busy = (r_state == S_RUN) || (r_state == S_DRAIN);
        o_done = (r_state == S_DONE);
    end

    // s_ready does not depend on s_valid.
    assign o_s_ready = w_run && !w_abort && w_adv && !w_pad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_w     <= '0;
            r_in_h     <= '0;
            r_out_w    <= '0;
            r_out_h    <= '0;
            r_cgrp_max <= '0;
            r_top      <= '0;
            r_left     <= '0;
            r_zp       <= '0;
            r_g        <= '0;
            r_c        <= '0;
            r_r        <= '0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_in_w     <= i_cfg_in_w;
                r_in_h     <= i_cfg_in_h;
                r_out_w    <= w_out_w;
                r_out_h    <= w_out_h;
                r_cgrp_max <= (i_cfg_cgrp == '0) ? '0 : i_cfg_cgrp - CGRP_W'(1);
                r_top      <= i_cfg_pad_top;
                r_left     <= i_cfg_pad_left;
                r_zp       <= i_cfg_zero_point;
                r_g        <= '0;
                r_c        <= '0;
                r_r        <= '0;
            end
            if (w_abort) begin
                r_m_valid <= 1'b0;
                r_g       <= '0;
                r_c       <= '0;
                r_r       <= '0;
            end else if (w_fire) begin
                r_m_data  <= w_pad ? {LANES{r_zp}} : i_s_data;
                r_m_valid <= 1'b1;
                // On the last beat all three counters wrap back to zero.
                if (w_g_max) begin
                    r_g <= '0;
                    if (w_c_max) begin
                        r_c <= '0;
                        r_r <= w_r_max ? '0 : r_r + SIZE_W'(1);
                    end else begin
                        r_c <= r_c + SIZE_W'(1);
                    end
                end else begin
                    r_g <= r_g + CGRP_W'(1);
                end
            end else if (i_m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign o_m_data  = r_m_data;
    assign o_m_valid = r_m_valid;
    assign o_out_w   = r_out_w;
    assign o_out_h   = r_out_h;

endmodule
